// File: rtl/axis_mat_loader.sv
// -----------------------------------------------------------------------------
// axis_mat_loader
//
// Purpose:
//   Loads one n x n matrix (n <= N_MAX) from an AXI-Stream into a downstream
//   LEN-deep shift register (LEN = N_MAX*N_MAX).
//   - Elements arrive row-major and are passed straight through as shift
//     strobes.
//   - Once the matrix ends (expected count reached, or an early tlast), the
//     register is topped up with zero shifts.
//   - Every start therefore produces exactly LEN shifts. Stream element j ends
//     up at downstream index j, and all indices past the received count hold 0.
//   - Framing and configuration problems raise a sticky error flag. The next
//     start clears it.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   start          one-cycle load request (honoured only when idle)
//   cfg_n          matrix dimension n, sampled with start
//   s_axis_tdata   stream element
//   s_axis_tvalid  stream valid
//   s_axis_tlast   marks the final matrix element
//   s_axis_tready  stream ready (high only while loading)
//   shift_en       shift strobe to the downstream register
//   shift_data     serial data to the downstream register
//   busy           high whenever a load is in progress
//   done           one-cycle pulse once the register contents are final
//   err            sticky framing/config error
// -----------------------------------------------------------------------------
module axis_mat_loader #(
  parameter int N_MAX = 4,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(N_MAX+1)-1:0]   cfg_n,
  input  logic [WIDTH-1:0]             s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic                         shift_en,
  output logic [WIDTH-1:0]             shift_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int LEN = N_MAX * N_MAX;
  localparam int CW  = $clog2(LEN + 1);

  // Value of the shift counter on the final shift of a load.
  localparam logic [CW-1:0] LAST_SHIFT = CW'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  // r_cnt counts every shift since start: data shifts first, then pads.
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [CW-1:0]   r_k;
  logic [CW-1:0]   w_k_next;
  logic            r_err;
  logic            w_err_next;

  logic [CW-1:0]   w_n_ext;
  logic [CW-1:0]   w_n_sq;
  logic            w_cfg_bad;
  logic            w_tready;
  logic            w_hs;
  logic            w_shift_en;
  logic [WIDTH-1:0] w_shift_data;
  logic            w_done;

  // n*n never exceeds LEN, so the product fits the counter width.
  assign w_n_ext   = CW'(cfg_n);
  assign w_n_sq    = w_n_ext * w_n_ext;
  assign w_cfg_bad = (cfg_n == '0) || (int'(cfg_n) > N_MAX);

  // Ready depends only on registered state. Masking it with rst means a beat
  // offered during reset is never taken and produces no shift.
  assign w_tready  = (r_state == S_LOAD) && !rst;
  assign w_hs      = s_axis_tvalid && w_tready;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_k_next     = r_k;
    w_err_next   = r_err;
    w_shift_en   = 1'b0;
    w_shift_data = '0;
    w_done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cnt_next = '0;
          if (w_cfg_bad) begin
            // No data is expected. Zero-fill the whole register instead.
            w_err_next   = 1'b1;
            w_k_next     = '0;
            w_state_next = S_PAD;
          end else begin
            w_err_next   = 1'b0;
            w_k_next     = w_n_sq;
            w_state_next = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (w_hs) begin
          w_shift_en   = 1'b1;
          w_shift_data = s_axis_tdata;
          w_cnt_next   = r_cnt + CW'(1);
          if (r_cnt == r_k - CW'(1)) begin
            // Last expected element. It must carry tlast.
            if (!s_axis_tlast) begin
              w_err_next = 1'b1;
            end
            // A full N_MAX x N_MAX matrix needs no padding.
            w_state_next = (r_cnt == LAST_SHIFT) ? S_DONE : S_PAD;
          end else if (s_axis_tlast) begin
            // Early tlast: the matrix is short, so pad out the rest.
            w_err_next   = 1'b1;
            w_state_next = S_PAD;
          end
        end
      end

      S_PAD: begin
        w_shift_en = 1'b1;
        w_cnt_next = r_cnt + CW'(1);
        if (r_cnt == LAST_SHIFT) begin
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_k     <= w_k_next;
      r_err   <= w_err_next;
    end
  end

  // Strobes are masked during reset so an aborted load emits no further shifts.
  assign s_axis_tready = w_tready;
  assign shift_en      = w_shift_en && !rst;
  assign shift_data    = rst ? '0 : w_shift_data;
  assign done          = w_done && !rst;
  assign busy          = (r_state != S_IDLE);
  assign err           = r_err;

endmodule

// File: tb/tb_axis_mat_loader.sv
module tb_axis_mat_loader;

  localparam int N_MAX = 4;
  localparam int WIDTH = 32;
  localparam int LEN   = N_MAX * N_MAX;
  localparam int NB    = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       cfg_n;
  logic [WIDTH-1:0] s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tlast;
  logic             s_axis_tready;
  logic             shift_en;
  logic [WIDTH-1:0] shift_data;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  axis_mat_loader #(.N_MAX(N_MAX), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_n         (cfg_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .shift_en      (shift_en),
    .shift_data    (shift_data),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream shift register model plus event counters, sampled mid-cycle.
  logic [WIDTH-1:0] sh [LEN];
  int m_shifts, m_dshifts, m_pad_bad, m_idle_bad, m_done, m_overlap;
  int m_last_shift, m_done_cyc;
  int mcyc = 0;

  always @(negedge clk) begin
    mcyc++;
    if (shift_en) begin
      for (int i = 0; i < LEN - 1; i++) sh[i] = sh[i+1];
      sh[LEN-1] = shift_data;
      m_shifts++;
      m_last_shift = mcyc;
      if (s_axis_tready) m_dshifts++;
      else if (shift_data != '0) m_pad_bad++;
    end else if (shift_data != '0) begin
      m_idle_bad++;
    end
    if (done) begin
      m_done++;
      m_done_cyc = mcyc;
      if (shift_en) m_overlap++;
    end
  end

  task automatic clear_mon();
    for (int i = 0; i < LEN; i++) sh[i] = 32'hDEADBEEF;
    m_shifts = 0; m_dshifts = 0; m_pad_bad = 0; m_idle_bad = 0;
    m_done = 0; m_overlap = 0; m_last_shift = -10; m_done_cyc = -20;
  endtask

  logic [WIDTH-1:0] beats [NB];

  // Reference model: matrix-level rules.
  function automatic int model_acc(input int n, input int tl);
    int k;
    if (n == 0 || n > N_MAX) return 0;
    k = n * n;
    if (tl >= 0 && tl < k) return tl + 1;
    return k;
  endfunction

  function automatic bit model_err(input int n, input int tl);
    if (n == 0 || n > N_MAX) return 1'b1;
    return (tl != n * n - 1);
  endfunction

  // One full load. vmode: 0 valid always, 1 valid on odd cycles, 2 random.
  task automatic run_vec(input int n, input int tl, input int vmode,
                         input int exp_acc, input bit exp_err, input string tag);
    int idx;
    bit hs;
    bit seen;
    int post;
    bit bad;
    bit v;
    idx = 0; hs = 1'b0; seen = 1'b0; post = 0;
    bad = (n == 0 || n > N_MAX);
    clear_mon();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (hs) idx++;
      if (seen) post++;
      if (post >= 3) break;
      start = (cyc == 0);
      cfg_n = 3'(n);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_axis_tvalid = v && (idx < NB);
      s_axis_tdata  = (idx < NB) ? beats[idx] : '0;
      s_axis_tlast  = (idx == tl);
      #2;
      hs = s_axis_tvalid && s_axis_tready;
      if (cyc == 1) begin
        check({tag, " err_after_start"}, err, bad);
        check({tag, " busy_after_start"}, busy, 1);
      end
      if (m_done > 0) seen = 1'b1;
    end
    start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    check({tag, " done_seen"}, seen, 1);
    check({tag, " accepted"}, idx, exp_acc);
    check({tag, " err"}, err, exp_err);
    check({tag, " busy_end"}, busy, 0);
    check({tag, " total_shifts"}, m_shifts, LEN);
    check({tag, " data_shifts"}, m_dshifts, exp_acc);
    check({tag, " done_count"}, m_done, 1);
    check({tag, " done_timing"}, m_done_cyc, m_last_shift + 1);
    check({tag, " pad_nonzero"}, m_pad_bad, 0);
    check({tag, " idle_data"}, m_idle_bad, 0);
    check({tag, " done_shift_overlap"}, m_overlap, 0);
    for (int j = 0; j < LEN; j++) begin
      check($sformatf("%s reg[%0d]", tag, j), sh[j], (j < exp_acc) ? beats[j] : '0);
    end
    $display("[TB] %s n=%0d tlast_at=%0d vmode=%0d accepted=%0d err=%0b shifts=%0d",
             tag, n, tl, vmode, idx, err, m_shifts);
  endtask

  typedef struct {
    int   n;
    int   tl;
    int   vmode;
    int   base;
    int   exp_acc;
    bit   exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, k, tl, vm;
    int idx;
    bit hs;

    tbl[0] = '{4, 15, 0, 32'h1,   16, 1'b0};
    tbl[1] = '{2,  3, 0, 32'hA,    4, 1'b0};
    tbl[2] = '{3,  8, 1, 32'h100,  9, 1'b0};
    tbl[3] = '{3,  3, 0, 32'h200,  4, 1'b1};
    tbl[4] = '{2, -1, 0, 32'h300,  4, 1'b1};
    tbl[5] = '{0, -1, 0, 32'h400,  0, 1'b1};
    tbl[6] = '{5, -1, 0, 32'h500,  0, 1'b1};
    tbl[7] = '{1,  0, 2, 32'h600,  1, 1'b0};

    rst = 1'b1; start = 1'b0; cfg_n = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tready", s_axis_tready, 0);
    check("reset shift_en", shift_en, 0);
    check("reset shift_data", shift_data, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);

    // Reset wins over start in the same cycle.
    @(posedge clk); #1;
    start = 1'b1; cfg_n = 3'd4;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    #2;
    check("rst_vs_start busy", busy, 0);
    check("rst_vs_start tready", s_axis_tready, 0);

    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < NB; j++) beats[j] = tbl[t].base + j;
      run_vec(tbl[t].n, tbl[t].tl, tbl[t].vmode, tbl[t].exp_acc, tbl[t].exp_err,
              $sformatf("vec%0d", t));
    end

    // Reset in the middle of a full-size load, right after the 5th beat.
    for (int j = 0; j < NB; j++) beats[j] = 32'h7000 + j;
    clear_mon();
    idx = 0; hs = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (hs) idx++;
      if (idx == 5) break;
      start = (cyc == 0); cfg_n = 3'd4;
      s_axis_tvalid = 1'b1; s_axis_tdata = beats[idx]; s_axis_tlast = 1'b0;
      #2;
      hs = s_axis_tvalid && s_axis_tready;
    end
    start = 1'b0;
    check("abort beats_before_rst", idx, 5);
    rst = 1'b1;
    s_axis_tdata = beats[idx];
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    check("abort busy", busy, 0);
    check("abort tready", s_axis_tready, 0);
    check("abort shift_en", shift_en, 0);
    check("abort err", err, 0);
    repeat (20) @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    check("abort done_count", m_done, 0);
    check("abort shifts", m_shifts, 5);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("abort reg[%0d]", LEN - 5 + j), sh[LEN-5+j], beats[j]);
    end
    $display("[TB] abort: shifts=%0d done_pulses=%0d", m_shifts, m_done);

    // Randomized loads checked against the reference model.
    for (int r = 0; r < 24; r++) begin
      n  = $urandom_range(0, 5);
      k  = (n >= 1 && n <= N_MAX) ? n * n : 0;
      tl = int'($urandom_range(0, k + 2)) - 1;
      vm = $urandom_range(0, 2);
      for (int j = 0; j < NB; j++) beats[j] = $urandom;
      run_vec(n, tl, vm, model_acc(n, tl), model_err(n, tl), $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
